clock_period_meter: RTL and testbench

//  Frequency/duty meter, the measuring end of clock_divider: samples a slow clock (e.g. clock_out
//  of clock_divider) in the fast clock_in domain and reports its period and high time.

---
 rtl/clock_period_meter.sv | 184 ++++++++++++++++++
 tb/tb_clock_period_meter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : clock_period_meter
//  Description : Measures the period and high time of a slow, asynchronous
//                clock (meas_clk) in fast clock_in cycles. It also flags a
//                stall when no rising edge arrives for TIMEOUT cycles.
//                Optional build macro CLK_METER_DUTY_EN enables the high-time
//                counter. Without it, high_time is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_period_meter #(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 50000000
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             meas_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    // Counters stick at all-ones rather than wrapping to a small, plausible value
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   sync_s;
    logic                   rise;
    logic                   to_hit;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~hist_q;
    assign to_hit = (cnt_q == TIMEOUT_LAST);

    // Synchronizer shift and edge-history tap
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], meas_clk};
        hist_d = sync_s;
    end

    // Measurement FSM: a rise beats the timeout threshold in the same cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        if (!enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_d   = '0;
                        state_d = ST_MEAS;
                    end else if (to_hit) begin
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        period_d     = sat_inc(cnt_q);
                        meas_valid_d = 1'b1;
                        cnt_d        = '0;
                        timeout_d    = 1'b0;
                        locked_d     = (sat_inc(cnt_q) == period_q);
                    end else if (to_hit) begin
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= '0;
            hist_q       <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            hist_q       <= hist_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

`ifdef CLK_METER_DUTY_EN
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] hi_next;

    assign hi_next = sync_s ? sat_inc(hi_q) : hi_q;

    // High-time accumulation: runs only while measuring; cleared on any restart
    always_comb begin
        hi_d        = '0;
        high_time_d = high_time_q;
        if (enable && (state_q == ST_MEAS)) begin
            if (rise) begin
                high_time_d = hi_next;
            end else if (!to_hit) begin
                hi_d = hi_next;
            end
        end
    end

    // High-time registers
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hi_q        <= '0;
            high_time_q <= '0;
        end else begin
            hi_q        <= hi_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_period_meter
//  Description : Self-checking bench for clock_period_meter. meas_clk is
//                driven as a sequence of (high, low) periods. Expected results
//                are queued when each measuring rise is driven. They are
//                compared whenever meas_valid pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clock_period_meter;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 100;

    logic             clock_in = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             meas_clk;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    clock_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .enable    (enable),
        .meas_clk  (meas_clk),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int   per;
        int   hi;
        logic lck;
    } exp_t;

    typedef struct {
        int h;
        int l;
        int reps;
        int exp_per;
        int exp_hi;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    int n_vec       = 0;
    int n_err       = 0;
    int cyc         = 0;
    int last_period = 0;
    int have_prev   = 0;
    int prev_per    = 0;
    int prev_hi     = 0;
    int rise_cyc    = 0;

    always @(posedge clock_in) cyc <= cyc + 1;

    function automatic int hi_exp(input int h);
        int r;
        r = h;
`ifndef CLK_METER_DUTY_EN
        r = 0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clock_in) begin
        exp_t e;
        if (reset_n === 1'b1 && meas_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_meas_valid: got pulse with period %0d, expected no pulse", period);
            end else begin
                e = sb_q.pop_front();
                check("period", period, e.per);
                check("high_time", high_time, hi_exp(e.hi));
                check("locked", locked, e.lck);
                check("timeout_at_valid", timeout, 0);
            end
        end
    end

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic idle(input int n);
        meas_clk = 1'b0;
        repeat (n) step();
    endtask

    // One meas_clk period; its rise closes the previous period, so queue that result
    task automatic drive_period(input int h, input int l, input int ep, input int eh);
        exp_t e;
        if (have_prev != 0) begin
            e.per = prev_per;
            e.hi  = prev_hi;
            e.lck = (prev_per == last_period);
            sb_q.push_back(e);
            last_period = prev_per;
        end
        meas_clk = 1'b1;
        rise_cyc = cyc;
        repeat (h) step();
        meas_clk = 1'b0;
        repeat (l) step();
        prev_per  = ep;
        prev_hi   = eh;
        have_prev = 1;
    endtask

    task automatic rearm();
        enable = 1'b0;
        idle(4);
        enable    = 1'b1;
        have_prev = 0;
    endtask

    task automatic finish_block();
        drive_period(1, 1, 2, 1);
        idle(4);
        have_prev = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) step();
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2, 2, 4, 4, 2};
        vecs[1] = '{3, 3, 3, 6, 3};
        vecs[2] = '{1, 1, 4, 2, 1};
        vecs[3] = '{5, 5, 3, 10, 5};
        vecs[4] = '{1, 3, 3, 4, 1};
        vecs[5] = '{3, 1, 3, 4, 3};

        reset_n  = 1'b0;
        enable   = 1'b0;
        meas_clk = 1'b0;
        repeat (3) @(negedge clock_in);
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
        reset_n = 1'b1;
        step();

        // Table run: back-to-back periods, including the 4 -> 6 switch
        rearm();
        for (int i = 0; i < 6; i++) begin
            repeat (vecs[i].reps) drive_period(vecs[i].h, vecs[i].l, vecs[i].exp_per, vecs[i].exp_hi);
        end
        finish_block();
        drain();

        // enable dropped mid-measurement
        rearm();
        repeat (3) drive_period(2, 2, 4, 2);
        enable = 1'b0;
        step();
        step();
        check("dis_locked", locked, 0);
        check("dis_period_hold", period, 4);
        check("dis_timeout", timeout, 0);
        have_prev = 0;
        repeat (3) begin
            meas_clk = 1'b1;
            step();
            step();
            meas_clk = 1'b0;
            step();
            step();
        end
        idle(4);
        check("dis_locked_still", locked, 0);
        drain();

        // Timeout after lock, then recovery at period 8
        rearm();
        repeat (4) drive_period(2, 2, 4, 2);
        while (cyc != rise_cyc + 102) @(negedge clock_in);
        check("to_before_timeout", timeout, 0);
        check("to_before_locked", locked, 1);
        @(negedge clock_in);
        check("to_at_timeout", timeout, 1);
        check("to_at_locked", locked, 0);
        check("to_period_hold", period, 4);
        have_prev = 0;
        step();
        repeat (2) drive_period(4, 4, 8, 4);
        idle(4);
        drain();
        check("to_cleared", timeout, 0);
        check("to_new_period", period, 8);

        // Asynchronous reset while measuring
        rearm();
        repeat (3) drive_period(2, 2, 4, 2);
        #2 reset_n = 1'b0;
        #1;
        check("arst_period", period, 0);
        check("arst_high_time", high_time, 0);
        check("arst_meas_valid", meas_valid, 0);
        check("arst_locked", locked, 0);
        check("arst_timeout", timeout, 0);
        sb_q.delete();
        last_period = 0;
        have_prev   = 0;
        @(negedge clock_in);
        @(negedge clock_in);
        reset_n = 1'b1;
        step();
        idle(3);
        repeat (3) drive_period(2, 2, 4, 2);
        finish_block();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
